// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: sequences byte bursts on a shared spi_master and
// round-robins ownership between two requesters, A and B.
`timescale 1ns/1ps
module spi_req_arbiter #(
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             reset,
  // requester A
  input  logic             a_req,
  input  logic [LEN_W-1:0] a_len,
  input  logic [7:0]       a_tx_data,
  output logic             a_grant,
  output logic             a_tx_pop,
  output logic [7:0]       a_rx_data,
  output logic             a_rx_valid,
  output logic             a_done,
  // requester B
  input  logic             b_req,
  input  logic [LEN_W-1:0] b_len,
  input  logic [7:0]       b_tx_data,
  output logic             b_grant,
  output logic             b_tx_pop,
  output logic [7:0]       b_rx_data,
  output logic             b_rx_valid,
  output logic             b_done,
  // status
  output logic             err,
  // spi_master side
  output logic             spi_start,
  output logic [7:0]       spi_data_in,
  input  logic [7:0]       spi_data_out,
  input  logic             spi_busy,
  input  logic             spi_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_t;

  // Owner encoding: 0 = A, 1 = B.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             last_owner;
  logic [LEN_W-1:0] remaining;
  logic [TW-1:0]    tmo_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             abort;
  logic [7:0]       data_q;

  logic             fire;
  logic             pick_b;
  logic [7:0]       owner_tx;
  logic             tmo_hit;

  // Shared decode: a byte launches only from START with the master idle.
  always_comb begin
    fire     = (state == S_START) && !spi_busy;
    pick_b   = b_req && (!a_req || (last_owner == OWN_A));
    owner_tx = (owner == OWN_B) ? b_tx_data : a_tx_data;
    tmo_hit  = (state == S_WAIT) && !spi_done && (tmo_cnt >= TMO_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (a_req || b_req) state_nxt = S_START;
      end
      S_START: begin
        if (!spi_busy) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done) begin
          if (remaining == '0)   state_nxt = S_FIN;
          else if (GAP_CYCLES == 0) state_nxt = S_START;
          else                   state_nxt = S_GAP;
        end else if (tmo_hit) begin
          state_nxt = S_FIN;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_START;
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: grant, length, timers, rx capture.
  // tmo_cnt is loaded with 1 at launch so it counts cycles elapsed since the
  // start pulse; the abort lands in FIN exactly TIMEOUT cycles after start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_A;
      last_owner <= OWN_B;
      remaining  <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      abort      <= 1'b0;
      data_q     <= '0;
      a_grant    <= 1'b0;
      b_grant    <= 1'b0;
      a_rx_data  <= '0;
      b_rx_data  <= '0;
      a_rx_valid <= 1'b0;
      b_rx_valid <= 1'b0;
    end else begin
      a_rx_valid <= 1'b0;
      b_rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            owner     <= pick_b;
            a_grant   <= !pick_b;
            b_grant   <= pick_b;
            remaining <= pick_b ? b_len : a_len;
          end
        end
        S_START: begin
          if (!spi_busy) begin
            data_q  <= owner_tx;
            tmo_cnt <= TW'(1);
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            if (owner == OWN_B) begin
              b_rx_data  <= spi_data_out;
              b_rx_valid <= 1'b1;
            end else begin
              a_rx_data  <= spi_data_out;
              a_rx_valid <= 1'b1;
            end
            if (remaining != '0) begin
              remaining <= remaining - LEN_W'(1);
              gap_cnt   <= '0;
            end
          end else if (tmo_hit) begin
            abort <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        S_FIN: begin
          a_grant    <= 1'b0;
          b_grant    <= 1'b0;
          last_owner <= owner;
          abort      <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode: strobes go only to the current owner.
  always_comb begin
    spi_start   = fire;
    spi_data_in = (state == S_START) ? owner_tx : data_q;
    a_tx_pop    = fire && (owner == OWN_A);
    b_tx_pop    = fire && (owner == OWN_B);
    a_done      = (state == S_FIN) && (owner == OWN_A);
    b_done      = (state == S_FIN) && (owner == OWN_B);
    err         = (state == S_FIN) && abort;
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: scoreboard bench with a behavioural SPI slave and two
// requester models sharing one negedge process.
`timescale 1ns/1ps
module tb_spi_req_arbiter;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned TIMEOUT    = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             a_req = 1'b0, b_req = 1'b0;
  logic [LEN_W-1:0] a_len = '0, b_len = '0;
  logic [7:0]       a_tx_data = '0, b_tx_data = '0;
  logic             a_grant, a_tx_pop, a_rx_valid, a_done;
  logic             b_grant, b_tx_pop, b_rx_valid, b_done;
  logic [7:0]       a_rx_data, b_rx_data;
  logic             err, spi_start;
  logic [7:0]       spi_data_in;
  logic [7:0]       spi_data_out = '0;
  logic             spi_busy;
  logic             spi_done = 1'b0;

  logic stall = 1'b0, no_done = 1'b0, model_busy = 1'b0;

  always #5 clk = ~clk;
  assign spi_busy = stall | model_busy;

  spi_req_arbiter #(.LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_len(a_len), .a_tx_data(a_tx_data), .a_grant(a_grant),
    .a_tx_pop(a_tx_pop), .a_rx_data(a_rx_data), .a_rx_valid(a_rx_valid), .a_done(a_done),
    .b_req(b_req), .b_len(b_len), .b_tx_data(b_tx_data), .b_grant(b_grant),
    .b_tx_pop(b_tx_pop), .b_rx_data(b_rx_data), .b_rx_valid(b_rx_valid), .b_done(b_done),
    .err(err), .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_done(spi_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues
  logic [7:0] q_spi[$];    // bytes the slave must receive
  logic [8:0] q_rx[$];     // {owner, byte} rx deliveries
  logic [1:0] q_done[$];   // {owner, err}
  logic       q_grant[$];  // grant order
  logic [7:0] a_txq[$], b_txq[$], s_txq[$];

  int  cyc = 0, start_cyc = 0, done_cyc = 0, n_starts = 0, grant_cnt = 0, s_cnt = 0;
  bit  prev_a = 0, prev_b = 0, done_in_grant = 0;
  bit  start_seen = 0, start_d = 0, a_pop_seen = 0, a_pop_d = 0, b_pop_seen = 0, b_pop_d = 0;
  logic [8:0] rx_got;
  logic [1:0] done_exp;

  // Observe DUT outputs first, then drive the slave and requester models.
  always @(negedge clk) begin
    cyc++;
    start_seen = 0; a_pop_seen = 0; b_pop_seen = 0;
    if (!reset) begin
      model_busy = 0; s_cnt = 0; spi_done = 0;
      start_d = 0; a_pop_d = 0; b_pop_d = 0;
      prev_a = 0; prev_b = 0; done_in_grant = 0;
    end else begin
      if (a_grant && !prev_a) begin
        grant_cnt++;
        check("grant_overlap_a", b_grant, 0);
        if (q_grant.size() == 0) check("grant_unexpected_a", 1, 0);
        else check("grant_owner", 0, q_grant.pop_front());
      end
      if (b_grant && !prev_b) begin
        grant_cnt++;
        check("grant_overlap_b", a_grant, 0);
        if (q_grant.size() == 0) check("grant_unexpected_b", 1, 0);
        else check("grant_owner", 1, q_grant.pop_front());
      end
      prev_a = a_grant; prev_b = b_grant;
      if (spi_start) begin
        n_starts++;
        check("start_while_busy", spi_busy, 0);
        if (q_spi.size() == 0) check("start_spurious", 1, 0);
        else check("slave_rx", spi_data_in, q_spi.pop_front());
        if (done_in_grant) check("gap_len", ((cyc - done_cyc) >= int'(GAP_CYCLES + 1)), 1);
        start_cyc = cyc; start_seen = 1;
      end
      if (a_tx_pop) begin check("a_pop_owner", {a_grant, b_grant, b_tx_pop}, 3'b100); a_pop_seen = 1; end
      if (b_tx_pop) begin check("b_pop_owner", {b_grant, a_grant, a_tx_pop}, 3'b100); b_pop_seen = 1; end
      if (a_rx_valid || b_rx_valid) begin
        check("rx_exclusive", {a_rx_valid, b_rx_valid, a_rx_valid ? a_grant : b_grant}, {a_rx_valid, !a_rx_valid, 1'b1});
        rx_got = a_rx_valid ? {1'b0, a_rx_data} : {1'b1, b_rx_data};
        if (q_rx.size() == 0) check("rx_spurious", 1, 0);
        else check("rx_data", rx_got, q_rx.pop_front());
      end
      if (a_done || b_done) begin
        check("done_exclusive", a_done & b_done, 0);
        if (q_done.size() == 0) check("done_spurious", 1, 0);
        else begin
          done_exp = q_done.pop_front();
          check("done_owner_err", {b_done, err}, done_exp);
          if (done_exp[0]) check("tmo_latency", cyc - start_cyc, TIMEOUT);
        end
      end else begin
        check("err_without_done", err, 0);
      end
      if (!a_grant && !b_grant) done_in_grant = 0;

      // slave model
      spi_done = 0;
      if (s_cnt != 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          model_busy = 0;
          if (!no_done) begin
            spi_done     = 1;
            spi_data_out = (s_txq.size() != 0) ? s_txq.pop_front() : 8'h00;
            done_cyc     = cyc;
            done_in_grant = 1;
          end
        end
      end
      if (start_d) begin model_busy = 1; s_cnt = 4; end
      start_d = start_seen;
      // requester models advance one cycle after the pop
      if (a_pop_d && a_txq.size() != 0) void'(a_txq.pop_front());
      if (b_pop_d && b_txq.size() != 0) void'(b_txq.pop_front());
      a_pop_d = a_pop_seen; b_pop_d = b_pop_seen;
    end
    a_tx_data = (a_txq.size() != 0) ? a_txq[0] : 8'h00;
    b_tx_data = (b_txq.size() != 0) ? b_txq[0] : 8'h00;
  end

  task automatic expect_burst(input logic who, input int n, input logic [7:0] tx0, input logic [7:0] txs,
                              input logic [7:0] rx0, input logic [7:0] rxs, input logic tmo);
    logic [7:0] t, r;
    t = tx0; r = rx0;
    q_grant.push_back(who);
    for (int i = 0; i < n; i++) begin
      if (who) b_txq.push_back(t); else a_txq.push_back(t);
      if (!tmo || i == 0) q_spi.push_back(t);
      if (!tmo) begin s_txq.push_back(r); q_rx.push_back({who, r}); end
      t = t + txs; r = r + rxs;
    end
    q_done.push_back({who, tmo});
  endtask

  task automatic wait_grant(input string tag, input int budget);
    int k = 0;
    while (!a_grant && !b_grant && k < budget) begin @(negedge clk); k++; end
    check(tag, a_grant | b_grant, 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while ((q_done.size() != 0 || a_grant || b_grant) && k < budget) begin @(negedge clk); k++; end
    check(tag, q_done.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {a_grant, a_tx_pop, a_rx_valid, a_done, b_grant, b_tx_pop, b_rx_valid, b_done, err, spi_start}, 0);
    check({tag, "_data"}, {a_rx_data, b_rx_data, spi_data_in}, 0);
  endtask

  int s0, g0, k;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(posedge clk) #1 reset = 1;

    // single byte from A
    expect_burst(0, 1, 8'hA5, 8'h00, 8'h3C, 8'h00, 0);
    a_len = 0; a_req = 1;
    wait_grant("t1_grant", 20); a_req = 0;
    wait_drain("t1_drain", 200);
    check("t1_a_rx_data", a_rx_data, 8'h3C);
    check("t1_b_rx_data", b_rx_data, 8'h00);

    // three-byte burst from B
    expect_burst(1, 3, 8'h11, 8'h11, 8'hC1, 8'h01, 0);
    b_len = 2; b_req = 1;
    wait_grant("t2_grant", 20); b_req = 0;
    wait_drain("t2_drain", 400);
    check("t2_b_rx_data", b_rx_data, 8'hC3);
    check("t2_a_rx_hold", a_rx_data, 8'h3C);

    // contention from reset release
    @(posedge clk) #1 reset = 0;
    a_len = 0; b_len = 0; a_req = 1; b_req = 1;
    expect_burst(0, 1, 8'h40, 8'h00, 8'h90, 8'h00, 0);
    expect_burst(1, 1, 8'h50, 8'h00, 8'h91, 8'h00, 0);
    expect_burst(0, 1, 8'h41, 8'h00, 8'h92, 8'h00, 0);
    expect_burst(1, 1, 8'h51, 8'h00, 8'h93, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    g0 = grant_cnt; k = 0;
    while (grant_cnt - g0 < 4 && k < 400) begin @(negedge clk); k++; end
    a_req = 0; b_req = 0;
    check("t3_four_grants", grant_cnt - g0, 4);
    wait_drain("t3_drain", 400);

    // busy stall after grant
    stall = 1;
    expect_burst(0, 1, 8'h77, 8'h00, 8'h88, 8'h00, 0);
    a_len = 0; a_req = 1;
    wait_grant("t4_grant", 20); a_req = 0;
    s0 = n_starts;
    repeat (20) @(negedge clk);
    check("t4_no_start_busy", n_starts - s0, 0);
    @(posedge clk) #1 stall = 0;
    wait_drain("t4_drain", 200);
    check("t4_one_start", n_starts - s0, 1);

    // timeout: slave never signals done
    no_done = 1;
    expect_burst(0, 4, 8'h61, 8'h01, 8'h00, 8'h00, 1);
    a_len = 3; a_req = 1;
    s0 = n_starts;
    wait_grant("t5_grant", 20); a_req = 0;
    wait_drain("t5_drain", 200);
    @(negedge clk);
    check("t5_one_start", n_starts - s0, 1);
    check("t5_idle", {a_grant, b_grant, spi_start}, 0);
    no_done = 0;
    a_txq.delete();

    // reset in the middle of a 4-byte burst
    expect_burst(0, 4, 8'hD0, 8'h01, 8'hE0, 8'h01, 0);
    a_len = 3; a_req = 1;
    s0 = n_starts;
    wait_grant("t6_grant", 20); a_req = 0;
    k = 0;
    while (n_starts == s0 && k < 50) begin @(negedge clk); k++; end
    check("t6_started", n_starts - s0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk) #2 reset = 0;
    #1 check_zero("t6_reset");
    q_spi.delete(); q_rx.delete(); q_done.delete(); q_grant.delete();
    a_txq.delete(); b_txq.delete(); s_txq.delete();
    repeat (4) @(negedge clk);
    check_zero("t6_held");
    @(posedge clk) #1 reset = 1;
    expect_burst(0, 1, 8'h5A, 8'h00, 8'hA5, 8'h00, 0);
    a_len = 0; a_req = 1;
    wait_grant("t6_regrant", 20); a_req = 0;
    wait_drain("t6_drain", 200);
    check("t6_a_rx_data", a_rx_data, 8'hA5);

    check("end_q_spi", q_spi.size(), 0);
    check("end_q_rx", q_rx.size(), 0);
    check("end_q_grant", q_grant.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
